// File: rtl/pfpu32_issue_ctrl.sv
// pfpu32_issue_ctrl: issue sequencer for the pfpu32 execution units
// (addsub, mul, div, i2f, f2i, cmp). Accepts one op at a time, pulses the
// selected unit's start, drives the shared advance/flush lines and hands the
// selected unit's result to writeback over a valid/ready handshake.
//
// Optional build macro PFPU32_WATCHDOG_EN adds a busy watchdog that flushes
// the unit pipelines and pulses timeout_o when a unit never reports ready.
module pfpu32_issue_ctrl #(
    parameter int NUM_UNITS   = 6,
    parameter int TIMEOUT_CYC = 32,
    parameter int CNT_W       = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 op_valid_i,
    input  logic [NUM_UNITS-1:0] op_sel_i,
    output logic                 op_ready_o,
    output logic [NUM_UNITS-1:0] start_o,
    output logic                 adv_o,
    output logic                 flush_o,
    input  logic [NUM_UNITS-1:0] rdy_i,
    output logic                 res_valid_o,
    output logic [NUM_UNITS-1:0] res_sel_o,
    input  logic                 res_ready_i,
    output logic                 inv_op_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [NUM_UNITS-1:0] UNIT_ONE = NUM_UNITS'(1);

    // The watchdog counter must be able to hold TIMEOUT_CYC-1.
    if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cnt_w_too_narrow
        $error("pfpu32_issue_ctrl: CNT_W too narrow for TIMEOUT_CYC");
    end

    state_e               state_q, state_d;
    logic [NUM_UNITS-1:0] sel_q, sel_d;
    logic                 inv_op_q, inv_op_d;
    logic                 hit;
    logic                 sel_onehot;
    logic                 wd_expire;

    // Only the accepted unit's ready bit counts; other units may be stale.
    assign hit        = |(rdy_i & sel_q);
    assign sel_onehot = (op_sel_i != '0) && ((op_sel_i & (op_sel_i - UNIT_ONE)) == '0);
    assign inv_op_o   = inv_op_q;

`ifdef PFPU32_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;
    logic             issue;

    assign issue     = (state_q == S_IDLE) && op_valid_i && sel_onehot && !flush_i;
    // A same-cycle hit wins, and a core flush already covers the timeout case.
    assign wd_expire = (state_q == S_BUSY) && !hit && !flush_i && (cnt_q == WD_LAST);
    assign timeout_o = timeout_q;

    // Watchdog count: restart on issue, count BUSY cycles spent waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (issue) begin
            cnt_d = '0;
        end else if ((state_q == S_BUSY) && !hit && !flush_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Watchdog registers; timeout_o reports the expiry one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= wd_expire;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // State, accepted select and invalid-op pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            inv_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            inv_op_q <= inv_op_d;
        end
    end

    // Next-state and output decode; a core flush overrides every state.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        inv_op_d    = 1'b0;
        op_ready_o  = 1'b0;
        start_o     = '0;
        adv_o       = 1'b0;
        flush_o     = flush_i;
        res_valid_o = 1'b0;
        res_sel_o   = '0;

        if (flush_i) begin
            state_d = S_IDLE;
            sel_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    op_ready_o = 1'b1;
                    if (op_valid_i) begin
                        if (sel_onehot) begin
                            start_o = op_sel_i;
                            adv_o   = 1'b1;
                            sel_d   = op_sel_i;
                            state_d = S_BUSY;
                        end else begin
                            // Accepted but dropped: nothing is started.
                            inv_op_d = 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    res_valid_o = hit;
                    res_sel_o   = hit ? sel_q : '0;
                    // Freeze the pipelines in the hit cycle itself so the
                    // unit's registered ready and result stay put.
                    adv_o       = ~(hit & ~res_ready_i);
                    if (hit) begin
                        if (res_ready_i) begin
                            state_d = S_IDLE;
                            sel_d   = '0;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end else if (wd_expire) begin
                        flush_o = 1'b1;
                        adv_o   = 1'b0;
                        state_d = S_IDLE;
                        sel_d   = '0;
                    end
                end
                S_HOLD: begin
                    res_valid_o = 1'b1;
                    res_sel_o   = sel_q;
                    if (res_ready_i) begin
                        state_d = S_IDLE;
                        sel_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pfpu32_issue_ctrl.sv
// Testbench for pfpu32_issue_ctrl: directed scenarios followed by randomized
// traffic checked by a scoreboard against a transaction-level model of the
// controller (issue -> result after the unit's depth, held until accepted).
module tb_pfpu32_issue_ctrl;

    localparam int NU = 6;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          op_valid_i = 1'b0;
    logic [NU-1:0] op_sel_i = '0;
    logic [NU-1:0] rdy_i = '0;
    logic          res_ready_i = 1'b0;
    logic          op_ready_o;
    logic [NU-1:0] start_o;
    logic          adv_o;
    logic          flush_o;
    logic          res_valid_o;
    logic [NU-1:0] res_sel_o;
    logic          inv_op_o;
    logic          timeout_o;

    pfpu32_issue_ctrl #(.NUM_UNITS(NU), .TIMEOUT_CYC(TO), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .op_valid_i(op_valid_i), .op_sel_i(op_sel_i), .op_ready_o(op_ready_o),
        .start_o(start_o), .adv_o(adv_o), .flush_o(flush_o), .rdy_i(rdy_i),
        .res_valid_o(res_valid_o), .res_sel_o(res_sel_o), .res_ready_i(res_ready_i),
        .inv_op_o(inv_op_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed issue: present a one-hot op for one cycle and check the start.
    task automatic issue(input logic [NU-1:0] sel);
        tick();
        op_valid_i = 1'b1;
        op_sel_i   = sel;
        #1;
        chk("issue_start", 32'(start_o), 32'(sel));
        chk("issue_adv", 32'(adv_o), 32'd1);
    endtask

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [NU-1:0] sel;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    int            inv_q[$];
    bit            mon_en = 1'b0;
    bit            seen = 1'b0;
    bit            act_on = 1'b0;
    logic [NU-1:0] act_sel = '0;
    int            act_due = 0;
    int            drv_start_cyc = -1;
    logic [NU-1:0] drv_start_val = '0;

    // Unit model: the active unit raises its ready once its depth has elapsed;
    // idle units toggle their ready bits randomly, writeback stalls randomly.
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            logic [NU-1:0] mask, hitv;
            mask = act_on ? act_sel : '0;
            hitv = (act_on && (cyc >= act_due)) ? act_sel : '0;
            rdy_i       = (NU'($urandom_range(0, 63)) & ~mask) | hitv;
            res_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare every output cycle against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("start_o", 32'(start_o), (drv_start_cyc == cyc) ? 32'(drv_start_val) : 32'd0);
            chk("flush_o_quiet", 32'(flush_o), 32'd0);
            chk("timeout_quiet", 32'(timeout_o), 32'd0);
            if (res_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("res_valid_spurious", 32'(res_valid_o), 32'd0);
                end else begin
                    chk("res_sel", 32'(res_sel_o), 32'(exp_q[0].sel));
                    if (!seen) begin
                        chk("latency", cyc, exp_q[0].due);
                        chk("adv_hit", 32'(adv_o), 32'(res_ready_i));
                        seen = 1'b1;
                    end else begin
                        chk("adv_hold", 32'(adv_o), 32'd0);
                    end
                    if (res_ready_i) begin
                        void'(exp_q.pop_front());
                        seen   = 1'b0;
                        act_on = 1'b0;
                    end
                end
            end else begin
                chk("res_sel_idle", 32'(res_sel_o), 32'd0);
                if (exp_q.size() > 0 && cyc >= exp_q[0].due)
                    chk("res_valid_missing", 32'(res_valid_o), 32'd1);
            end
            if (inv_q.size() > 0 && inv_q[0] == cyc) begin
                chk("inv_op_pulse", 32'(inv_op_o), 32'd1);
                void'(inv_q.pop_front());
            end else begin
                chk("inv_op_quiet", 32'(inv_op_o), 32'd0);
            end
        end
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL tb_time_limit: simulation did not finish, got running, expected done");
        $fatal(1, "time limit");
    end

    initial begin
        logic [NU-1:0] bad [2];
        bad[0] = 6'b000110;
        bad[1] = 6'b000000;

        // ---------------- reset ----------------
        tick();
        #1;
        chk("rst_op_ready", 32'(op_ready_o), 32'd1);
        chk("rst_adv", 32'(adv_o), 32'd0);
        chk("rst_res_valid", 32'(res_valid_o), 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_inv", 32'(inv_op_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        tick();
        rst = 1'b0;

        // ---------------- f2i, 3-cycle unit ----------------
        issue(6'b010000);
        for (int k = 1; k <= 2; k++) begin
            tick();
            op_valid_i  = 1'b0;
            rdy_i       = '0;
            res_ready_i = 1'b1;
            #1;
            chk("f2i_wait_valid", 32'(res_valid_o), 32'd0);
            chk("f2i_wait_adv", 32'(adv_o), 32'd1);
            chk("f2i_busy_ready", 32'(op_ready_o), 32'd0);
        end
        tick();
        rdy_i = 6'b010000;
        #1;
        chk("f2i_res_valid", 32'(res_valid_o), 32'd1);
        chk("f2i_res_sel", 32'(res_sel_o), 32'h10);
        chk("f2i_adv_accept", 32'(adv_o), 32'd1);
        tick();
        rdy_i       = '0;
        res_ready_i = 1'b0;
        #1;
        chk("f2i_back_idle", 32'(op_ready_o), 32'd1);
        chk("f2i_valid_drop", 32'(res_valid_o), 32'd0);

        // ---------------- writeback stall ----------------
        issue(6'b010000);
        for (int k = 1; k <= 2; k++) begin
            tick();
            op_valid_i = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            rdy_i       = 6'b010000;
            res_ready_i = 1'b0;
            #1;
            chk("stall_valid", 32'(res_valid_o), 32'd1);
            chk("stall_adv", 32'(adv_o), 32'd0);
            chk("stall_sel", 32'(res_sel_o), 32'h10);
        end
        tick();
        res_ready_i = 1'b1;
        #1;
        chk("stall_release_valid", 32'(res_valid_o), 32'd1);
        chk("stall_release_adv", 32'(adv_o), 32'd0);
        tick();
        rdy_i       = '0;
        res_ready_i = 1'b0;
        #1;
        chk("stall_idle", 32'(op_ready_o), 32'd1);
        chk("stall_valid_off", 32'(res_valid_o), 32'd0);

        // ---------------- invalid select ----------------
        for (int b = 0; b < 2; b++) begin
            tick();
            op_valid_i = 1'b1;
            op_sel_i   = bad[b];
            #1;
            chk("inv_no_start", 32'(start_o), 32'd0);
            chk("inv_ready", 32'(op_ready_o), 32'd1);
            chk("inv_no_adv", 32'(adv_o), 32'd0);
            tick();
            op_valid_i = 1'b0;
            #1;
            chk("inv_pulse", 32'(inv_op_o), 32'd1);
            chk("inv_still_idle", 32'(op_ready_o), 32'd1);
            tick();
            #1;
            chk("inv_pulse_end", 32'(inv_op_o), 32'd0);
        end

        // ---------------- flush in HOLD with res_ready ----------------
        issue(6'b000010);
        tick();
        op_valid_i  = 1'b0;
        rdy_i       = 6'b000010;
        res_ready_i = 1'b0;
        #1;
        chk("hold_pre_valid", 32'(res_valid_o), 32'd1);
        tick();
        #1;
        chk("hold_valid", 32'(res_valid_o), 32'd1);
        tick();
        flush_i     = 1'b1;
        res_ready_i = 1'b1;
        #1;
        chk("flush_o", 32'(flush_o), 32'd1);
        chk("flush_valid", 32'(res_valid_o), 32'd0);
        chk("flush_adv", 32'(adv_o), 32'd0);
        tick();
        flush_i     = 1'b0;
        res_ready_i = 1'b0;
        #1;
        chk("flush_idle", 32'(op_ready_o), 32'd1);
        chk("flush_no_result", 32'(res_valid_o), 32'd0);

        // ---------------- flush blocks an op in IDLE ----------------
        tick();
        rdy_i      = '0;
        flush_i    = 1'b1;
        op_valid_i = 1'b1;
        op_sel_i   = 6'b000001;
        #1;
        chk("flush_idle_no_start", 32'(start_o), 32'd0);
        tick();
        flush_i    = 1'b0;
        op_valid_i = 1'b0;
        rdy_i      = 6'b000001;
        #1;
        chk("flush_op_dropped", 32'(op_ready_o), 32'd1);
        chk("flush_op_no_valid", 32'(res_valid_o), 32'd0);

        // ---------------- asynchronous reset mid-BUSY ----------------
        rdy_i = '0;
        issue(6'b000100);
        tick();
        op_valid_i  = 1'b0;
        rdy_i       = 6'b000100;
        res_ready_i = 1'b0;
        #1;
        chk("arst_pre_valid", 32'(res_valid_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_op_ready", 32'(op_ready_o), 32'd1);
        chk("arst_adv", 32'(adv_o), 32'd0);
        chk("arst_valid", 32'(res_valid_o), 32'd0);
        tick();
        rst   = 1'b0;
        rdy_i = '0;

        // ---------------- watchdog ----------------
`ifdef PFPU32_WATCHDOG_EN
        issue(6'b000100);
        for (int k = 1; k < TO; k++) begin
            tick();
            op_valid_i = 1'b0;
            rdy_i      = '0;
            #1;
            chk("wd_no_flush", 32'(flush_o), 32'd0);
        end
        tick();
        #1;
        chk("wd_flush", 32'(flush_o), 32'd1);
        chk("wd_adv", 32'(adv_o), 32'd0);
        tick();
        #1;
        chk("wd_timeout_pulse", 32'(timeout_o), 32'd1);
        chk("wd_idle", 32'(op_ready_o), 32'd1);
        tick();
        #1;
        chk("wd_timeout_end", 32'(timeout_o), 32'd0);

        issue(6'b000100);
        for (int k = 1; k < TO; k++) begin
            tick();
            op_valid_i = 1'b0;
        end
        tick();
        rdy_i       = 6'b000100;
        res_ready_i = 1'b1;
        #1;
        chk("wd_hit_valid", 32'(res_valid_o), 32'd1);
        chk("wd_hit_no_flush", 32'(flush_o), 32'd0);
        tick();
        rdy_i       = '0;
        res_ready_i = 1'b0;
        #1;
        chk("wd_hit_no_timeout", 32'(timeout_o), 32'd0);
        chk("wd_hit_idle", 32'(op_ready_o), 32'd1);
`else
        issue(6'b000100);
        for (int k = 0; k < TO + 8; k++) begin
            tick();
            op_valid_i = 1'b0;
            #1;
            chk("nowd_no_timeout", 32'(timeout_o), 32'd0);
        end
        chk("nowd_no_flush", 32'(flush_o), 32'd0);
        chk("nowd_still_busy", 32'(op_ready_o), 32'd0);
        tick();
        rdy_i       = 6'b000100;
        res_ready_i = 1'b1;
        #1;
        chk("nowd_late_valid", 32'(res_valid_o), 32'd1);
        tick();
        rdy_i       = '0;
        res_ready_i = 1'b0;
`endif

        // ---------------- randomized traffic ----------------
        tick();
        mon_en = 1'b1;
        for (int t = 0; t < 150; t++) begin
            int            guard;
            int            d;
            logic [NU-1:0] sel;
            guard = 0;
            tick();
            op_valid_i = 1'b0;
            while (!op_ready_o && guard < 400) begin
                tick();
                guard++;
            end
            if (guard >= 400) begin
                chk("drv_ready_wait", 32'(op_ready_o), 32'd1);
                break;
            end
            if ($urandom_range(0, 9) < 8) begin
                sel = NU'(1) << $urandom_range(0, NU - 1);
                d   = $urandom_range(1, 5);
                act_sel = sel;
                act_due = cyc + d;
                act_on  = 1'b1;
                exp_q.push_back('{sel: sel, due: cyc + d});
                drv_start_cyc = cyc;
                drv_start_val = sel;
            end else begin
                do sel = NU'($urandom_range(0, 63)); while ($countones(sel) == 1);
                inv_q.push_back(cyc + 1);
            end
            op_valid_i = 1'b1;
            op_sel_i   = sel;
        end
        tick();
        op_valid_i = 1'b0;
        for (int g = 0; g < 400 && exp_q.size() > 0; g++) tick();
        repeat (3) tick();
        mon_en = 1'b0;
        chk("drain_results", 32'(exp_q.size()), 32'd0);
        chk("drain_inv", 32'(inv_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pfpu32_issue_ctrl.md
Name: pfpu32_issue_ctrl

Overview:
- Issue sequencer for the pfpu32 execution units: add/sub, mul, div, i2f, f2i and cmp.
- Accepts one FPU operation at a time from decode and pulses the selected unit's start.
- Drives the shared advance and flush lines of every unit pipeline and watches the selected unit's ready.
- Presents the result to writeback with a valid/ready handshake, holding the unit pipelines frozen until writeback accepts.

Parameters:
- NUM_UNITS, 6: number of execution units; one start/ready bit per unit. Bit order: 0 addsub, 1 mul, 2 div, 3 i2f, 4 f2i, 5 cmp.
- TIMEOUT_CYC, 32: watchdog limit in cycles; used only with the optional feature.
- CNT_W, 6: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  pipeline flush from the core
- op_valid_i  in  1  decode presents an FPU op
- op_sel_i  in  NUM_UNITS  one-hot unit select
- op_ready_o  out  1  controller can accept an op
- start_o  out  NUM_UNITS  one-cycle start pulse to the selected unit
- adv_o  out  1  advance to all unit pipelines
- flush_o  out  1  flush to all unit pipelines
- rdy_i  in  NUM_UNITS  per-unit result-ready (registered in the units)
- res_valid_o  out  1  result available
- res_sel_o  out  NUM_UNITS  one-hot source of the result, for the writeback mux
- res_ready_i  in  1  writeback accepts the result
- inv_op_o  out  1  one-cycle pulse: invalid op_sel_i was dropped
- timeout_o  out  1  one-cycle pulse: watchdog expired

Behaviour:
- Reset (async):
  - state = IDLE; sel_q = 0.
  - All registered outputs are 0 (inv_op_o, timeout_o, watchdog count).
  - Combinational outputs follow IDLE: op_ready_o=1, others 0.
- States: IDLE, BUSY, HOLD. sel_q is a registered copy of the accepted op_sel_i.
- flush_i has priority over everything, in any state:
  - flush_o = flush_i (combinational).
  - start_o = 0, res_valid_o = 0, adv_o = 0 in that cycle.
  - Next state = IDLE, sel_q = 0.
  - Any op presented in that cycle is not accepted.
- IDLE:
  - op_ready_o = 1.
  - Valid op with op_sel_i one-hot: op is accepted and
    - start_o = op_sel_i and adv_o = 1, same cycle;
    - sel_q <= op_sel_i; next state BUSY.
  - Valid op with op_sel_i zero or multi-hot: op is accepted but dropped.
    - No start; inv_op_o = 1 on the next cycle; state stays IDLE.
- BUSY:
  - op_ready_o = 0; start_o = 0.
  - hit = |(rdy_i & sel_q).
  - res_valid_o = hit; res_sel_o = sel_q when hit, else 0.
  - adv_o = ~(hit & ~res_ready_i). This freezes the unit pipelines in the same cycle, so the registered rdy and results are retained.
  - hit & res_ready_i: next state IDLE. The next op is accepted no earlier than the following cycle; back-to-back issue costs one cycle.
  - hit & ~res_ready_i: next state HOLD.
  - Rdy bits of units other than sel_q are ignored.
- HOLD:
  - adv_o = 0; res_valid_o = 1; res_sel_o = sel_q; op_ready_o = 0.
  - res_ready_i: next state IDLE.
- Latency: issue-to-res_valid_o equals the unit's pipeline depth; the controller adds no cycles.
- res_valid_o never deasserts without res_ready_i, except on flush_i or timeout.

Optional Feature:
- Macro: PFPU32_WATCHDOG_EN.
- Enabled:
  - CNT_W-bit counter clears on issue and increments each BUSY cycle without hit.
  - When the count reaches TIMEOUT_CYC-1 in BUSY and hit = 0, that cycle:
    - flush_o = 1 and adv_o = 0;
    - timeout_o = 1 on the next cycle;
    - next state IDLE.
  - Same-cycle hit wins over timeout.
- Disabled: no counter; timeout_o tied 0.

Test Plan:
- Reset mid-BUSY: assert rst asynchronously with no clock edge -> state IDLE, op_ready_o=1, adv_o=0, res_valid_o=0 immediately.
- f2i issue, 3-cycle unit:
  - op_sel_i=6'b010000 with op_valid_i for one cycle -> start_o=6'b010000 and adv_o=1 that cycle.
  - rdy_i[4]=1 three cycles later -> res_valid_o=1, res_sel_o=6'b010000.
  - res_ready_i=1 -> IDLE next cycle.
- Writeback stall: rdy_i[4]=1, res_ready_i=0 for 4 cycles -> adv_o=0 from the first hit cycle, res_valid_o held 4 cycles, IDLE the cycle after res_ready_i=1.
- Invalid select: op_sel_i=6'b000110 or 6'b000000 -> no start_o bit, inv_op_o=1 for exactly one cycle next cycle, op_ready_o stays 1.
- Flush in HOLD with res_ready_i=1 in the same cycle -> flush_o=1, res_valid_o=0, next state IDLE, no result handshake.
- PFPU32_WATCHDOG_EN, TIMEOUT_CYC=32: issue div and never raise rdy_i[2] -> flush_o=1 on the 32nd BUSY cycle, timeout_o pulse the next cycle, op_ready_o=1.
- Same setup, rdy_i[2]=1 on the 32nd cycle -> result delivered, no timeout.
